sram_1rw1r_bmask: RTL

- Parametrised successor to the 32x128 single-port macro model.
- Port 0 is read/write with a per-byte write mask. Port 1 is read-only.
- Configurable output pipeline depth, read-valid strobes, and an optional post-reset zero-fill sequencer.
- Sits between bus adapters and compute blocks wherever two concurrent accessors share one storage array.

---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_out_pipe.sv | 47 ++++
 rtl/sram_1rw1r_bmask.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for the sram_1rw1r_bmask macro model.
//   ST_INIT / ST_READY : zero-fill sequencer states
//   num_wmasks()       : number of byte-enable bits for a given word width
package sram_pkg;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } sram_state_e;

    localparam int BYTE_W = 8;

    function automatic int num_wmasks(input int data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

// File: rtl/sram_out_pipe.sv
// sram_out_pipe: DEPTH-stage delay line for a read port's {valid, data}.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low clear of all stages
//   valid_i : read-data valid from the array stage
//   data_i  : read data from the array stage
//   valid_o : delayed valid strobe
//   data_o  : delayed data; holds the last valid word between reads
module sram_out_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign valid_o = valid_i;
        assign data_o  = data_i;
    end else begin : g_stages
        logic [DEPTH-1:0] valid_q;
        logic [WIDTH-1:0] data_q [DEPTH];
        // Data only advances alongside a valid bit, so every stage (and the
        // output) keeps the most recent read word while the pipe is idle.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= '0;
                for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
            end else begin
                valid_q[0] <= valid_i;
                if (valid_i) data_q[0] <= data_i;
                for (int i = 1; i < DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) data_q[i] <= data_q[i-1];
                end
            end
        end
        assign valid_o = valid_q[DEPTH-1];
        assign data_o  = data_q[DEPTH-1];
    end

endmodule

// File: rtl/sram_1rw1r_bmask.sv
// sram_1rw1r_bmask: one read/write port with byte mask plus one read-only
// port over a shared array, registered inputs, optional output pipeline and
// optional post-reset zero-fill.
//   clk0   : clock, rising edge
//   rstb0  : asynchronous active-low reset
//   csb0   : port 0 chip select (active low)
//   web0   : port 0 write enable (active low)
//   wmask0 : port 0 byte enables (active high)
//   addr0  : port 0 address
//   din0   : port 0 write data
//   dout0  : port 0 read data
//   dvld0  : port 0 read-data valid strobe
//   csb1   : port 1 chip select (active low, read only)
//   addr1  : port 1 address
//   dout1  : port 1 read data
//   dvld1  : port 1 read-data valid strobe
//   busy   : zero-fill in progress; requests are dropped
module sram_1rw1r_bmask
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int NUM_WMASKS = num_wmasks(DATA_WIDTH),
    parameter int OUT_REGS   = 0,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dvld0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dvld1,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    sram_state_e           state_q;
    logic [ADDR_WIDTH-1:0] init_addr_q;
    logic                  csb0_q, web0_q, csb1_q;
    logic [NUM_WMASKS-1:0] wmask0_q;
    logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
    logic [DATA_WIDTH-1:0] din0_q;
    logic                  v0_q, v1_q;
    logic [DATA_WIDTH-1:0] d0_q, d1_q, d0_d, d1_d;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic                  ready, rd0, wr0, rd1;

    assign ready = state_q == ST_READY;
    assign busy  = ~ready;
    assign rd0   = ~csb0_q & web0_q;
    assign wr0   = ~csb0_q & ~web0_q;
    assign rd1   = ~csb1_q;
    assign d0_d  = mem[addr0_q];
    assign d1_d  = mem[addr1_q];

    // Requests sampled while filling are turned into deselects at the input
    // register, so nothing sampled during INIT can act once READY is reached.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state_q     <= INIT_ZERO ? ST_INIT : ST_READY;
            init_addr_q <= '0;
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            wmask0_q    <= '0;
            addr0_q     <= '0;
            din0_q      <= '0;
            csb1_q      <= 1'b1;
            addr1_q     <= '0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            d0_q        <= '0;
            d1_q        <= '0;
        end else begin
            csb0_q   <= csb0 | ~ready;
            web0_q   <= web0;
            wmask0_q <= wmask0;
            addr0_q  <= addr0;
            din0_q   <= din0;
            csb1_q   <= csb1 | ~ready;
            addr1_q  <= addr1;
            v0_q     <= rd0;
            v1_q     <= rd1;
            if (rd0) d0_q <= d0_d;
            if (rd1) d1_q <= d1_d;
            if (!ready) begin
                init_addr_q <= init_addr_q + 1'b1;
                if (init_addr_q == LAST_ADDR) state_q <= ST_READY;
            end
        end
    end

    // Array writes use non-blocking updates on the same edge as the reads
    // above, which gives read-before-write on a same-address collision.
    always_ff @(posedge clk0) begin
        if (!ready) begin
            mem[init_addr_q] <= '0;
        end else if (wr0) begin
            for (int i = 0; i < NUM_WMASKS; i++)
                if (wmask0_q[i]) mem[addr0_q][8*i +: 8] <= din0_q[8*i +: 8];
        end
    end

    sram_out_pipe #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(OUT_REGS)
    ) u_pipe0 (
        .clk_i  (clk0),
        .rst_ni (rstb0),
        .valid_i(v0_q),
        .data_i (d0_q),
        .valid_o(dvld0),
        .data_o (dout0)
    );

    sram_out_pipe #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(OUT_REGS)
    ) u_pipe1 (
        .clk_i  (clk0),
        .rst_ni (rstb0),
        .valid_i(v1_q),
        .data_i (d1_q),
        .valid_o(dvld1),
        .data_o (dout1)
    );

endmodule
